// File: rtl/counter_seq_ctrl_pkg.sv
// counter_seq_ctrl_pkg: state encoding and mode constants shared by the timer controller
package counter_seq_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2} state_t;
  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;
endpackage

// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: interval-timer policy wrapped around an external cascaded 4-bit counter chain
module counter_seq_ctrl
  import counter_seq_ctrl_pkg::*;
#(
  parameter int STAGES = 2,
  parameter int TCNT_W = 8,
  localparam int W = 4 * STAGES
) (
  input  logic              CLK,
  input  logic              CLR_n,
  input  logic              start,
  input  logic              stop,
  input  logic              hold,
  input  logic              mode,
  input  logic [W-1:0]      period,
  input  logic              cnt_rco,
  output logic [W-1:0]      cnt_d,
  output logic              cnt_load_n,
  output logic              cnt_enp,
  output logic              cnt_ent,
  output logic              busy,
  output logic              tick,
  output logic              done,
  output logic              err,
  output logic [TCNT_W-1:0] tick_cnt
);
  state_t state, state_nx;
  logic   mode_q, stop_hit, accept, rco_hit;
  always_comb begin
    stop_hit   = stop && state != IDLE;
    accept     = state == IDLE && start && period != '0;
    rco_hit    = state == RUN && cnt_rco && !stop;
    state_nx   = stop_hit ? IDLE
               : state == IDLE ? (accept ? LOAD : IDLE)
               : state == LOAD ? RUN
               : (rco_hit && mode_q == MODE_ONESHOT) ? IDLE : RUN;
    // a periodic reload rides on the terminal-count cycle; load wins over count in the chain
    cnt_load_n = !(state == LOAD || (state == RUN && cnt_rco && mode_q == MODE_PERIODIC));
    cnt_enp    = state == RUN && !hold && !stop;
    cnt_ent    = state == RUN && !hold;
    busy       = state != IDLE;
  end
  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      state    <= IDLE;
      mode_q   <= MODE_ONESHOT;
      cnt_d    <= '0;
      tick     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      tick_cnt <= '0;
    end else begin
      state <= state_nx;
      tick  <= rco_hit;
      done  <= stop_hit || (rco_hit && mode_q == MODE_ONESHOT);
      if (accept) begin
        mode_q   <= mode;
        cnt_d    <= -period;
        tick_cnt <= '0;
        err      <= 1'b0;
      end else if (state == IDLE && start) begin
        err <= 1'b1;
      end
      if (rco_hit && tick_cnt != '1) tick_cnt <= tick_cnt + TCNT_W'(1);
    end
  end
endmodule

// File: tb/tb_counter_seq_ctrl.sv
// tb_counter_seq_ctrl: directed bench with a behavioural 4-bit counter chain and a tick-time scoreboard
module tb_counter_seq_ctrl;
  localparam int STAGES = 2;
  localparam int W = 4 * STAGES;
  localparam int TCNT_W = 8;
  logic              CLK = 1'b0;
  logic              CLR_n = 1'b0;
  logic              start = 1'b0, stop = 1'b0, hold = 1'b0, mode = 1'b0;
  logic [W-1:0]      period = '0;
  logic              cnt_rco;
  logic [W-1:0]      cnt_d;
  logic              cnt_load_n, cnt_enp, cnt_ent, busy, tick, done, err;
  logic [TCNT_W-1:0] tick_cnt;
  logic [W-1:0]      chain_q;
  logic [STAGES-1:0] en_s;
  int                vectors = 0, miss = 0, cyc = 0, n = 0;
  int                exp_q[$];

  counter_seq_ctrl #(.STAGES(STAGES), .TCNT_W(TCNT_W)) dut (
    .CLK(CLK), .CLR_n(CLR_n), .start(start), .stop(stop), .hold(hold), .mode(mode),
    .period(period), .cnt_rco(cnt_rco), .cnt_d(cnt_d), .cnt_load_n(cnt_load_n),
    .cnt_enp(cnt_enp), .cnt_ent(cnt_ent), .busy(busy), .tick(tick), .done(done),
    .err(err), .tick_cnt(tick_cnt)
  );

  always #5 CLK = ~CLK;

  // chain model: each stage counts when ENP and its ENT are high; RCO = ENT & Q==F feeds the next ENT
  always_comb begin
    logic e;
    en_s = '0;
    e = cnt_ent;
    for (int i = 0; i < STAGES; i++) begin
      en_s[i] = e;
      e = e && chain_q[4*i +: 4] == 4'hF;
    end
    cnt_rco = e;
  end
  always_ff @(posedge CLK or negedge CLR_n)
    if (!CLR_n) chain_q <= '0;
    else if (!cnt_load_n) chain_q <= cnt_d;
    else for (int i = 0; i < STAGES; i++)
      if (cnt_enp && en_s[i]) chain_q[4*i +: 4] <= chain_q[4*i +: 4] + 4'd1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    int e;
    @(posedge CLK);
    #1;
    cyc++;
    if (tick === 1'b1) begin
      chk("tick_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("tick_cycle", cyc, e);
      end
    end
  endtask

  task automatic go(input logic [W-1:0] p, input logic m, output int nn);
    start = 1'b1; period = p; mode = m;
    step();
    start = 1'b0;
    nn = cyc;
  endtask

  initial begin
    #2;
    chk("rst_cnt_d", cnt_d, 0);
    chk("rst_load_n", cnt_load_n, 1);
    chk("rst_enp", cnt_enp, 0);
    chk("rst_ent", cnt_ent, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tick", tick, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_tick_cnt", tick_cnt, 0);
    CLR_n = 1'b1;
    step();
    // one-shot, period 5
    go(8'd5, 1'b0, n);
    exp_q.push_back(n + 6);
    chk("os_cnt_d", cnt_d, 8'hFB);
    chk("os_load", cnt_load_n, 0);
    chk("os_busy", busy, 1);
    chk("os_load_enp", cnt_enp, 0);
    step();
    chk("os_q1", chain_q, 8'hFB);
    chk("os_run_load_n", cnt_load_n, 1);
    chk("os_run_enp", cnt_enp, 1);
    chk("os_rco_early", cnt_rco, 0);
    repeat (4) step();
    chk("os_q5", chain_q, 8'hFF);
    chk("os_rco5", cnt_rco, 1);
    step();
    chk("os_tick", tick, 1);
    chk("os_done", done, 1);
    chk("os_tick_cnt", tick_cnt, 1);
    chk("os_busy_end", busy, 0);
    step();
    chk("os_done_pulse", done, 0);
    chk("os_queue", exp_q.size(), 0);
    // periodic, period 3, ten periods
    go(8'd3, 1'b1, n);
    for (int k = 1; k <= 10; k++) exp_q.push_back(n + 1 + 3 * k);
    for (int i = 1; i <= 30; i++) begin
      step();
      chk("per_rco", cnt_rco, (i % 3) == 0);
      chk("per_load_n", cnt_load_n, (i % 3) != 0);
    end
    step();
    chk("per_tick_cnt", tick_cnt, 10);
    chk("per_queue", exp_q.size(), 0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("per_stop_done", done, 1);
    chk("per_stop_busy", busy, 0);
    chk("per_stop_cnt", tick_cnt, 10);
    step();
    // stop in IDLE is ignored
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("idle_stop_done", done, 0);
    // pause, then abort coincident with terminal count
    go(8'd4, 1'b1, n);
    exp_q.push_back(n + 5);
    exp_q.push_back(n + 11);
    repeat (5) step();
    chk("hold_reload_q", chain_q, 8'hFC);
    repeat (2) step();
    chk("hold_pre_q", chain_q, 8'hFE);
    hold = 1'b1;
    #1;
    chk("hold_enp", cnt_enp, 0);
    chk("hold_ent", cnt_ent, 0);
    step();
    chk("hold_q1", chain_q, 8'hFE);
    chk("hold_rco", cnt_rco, 0);
    step();
    chk("hold_q2", chain_q, 8'hFE);
    hold = 1'b0;
    step();
    chk("hold_rco_late", cnt_rco, 1);
    step();
    chk("hold_tick", tick, 1);
    repeat (3) step();
    chk("abort_rco", cnt_rco, 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("abort_tick", tick, 0);
    chk("abort_done", done, 1);
    chk("abort_busy", busy, 0);
    chk("abort_tick_cnt", tick_cnt, 2);
    step();
    chk("abort_done_pulse", done, 0);
    chk("abort_queue", exp_q.size(), 0);
    // illegal period, then period 1 with a start while busy
    go(8'd0, 1'b0, n);
    chk("err_set", err, 1);
    chk("err_busy", busy, 0);
    step();
    chk("err_sticky", err, 1);
    go(8'd1, 1'b1, n);
    for (int k = 1; k <= 3; k++) exp_q.push_back(n + 1 + k);
    chk("err_clear", err, 0);
    chk("p1_cnt_d", cnt_d, 8'hFF);
    step();
    chk("p1_rco1", cnt_rco, 1);
    step();
    chk("p1_rco2", cnt_rco, 1);
    start = 1'b1; period = 8'd5; mode = 1'b0;
    step();
    start = 1'b0;
    chk("busy_start_cnt_d", cnt_d, 8'hFF);
    chk("busy_start_busy", busy, 1);
    chk("p1_rco3", cnt_rco, 1);
    step();
    chk("p1_rco4", cnt_rco, 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("p1_tick_cnt", tick_cnt, 3);
    chk("p1_done", done, 1);
    chk("p1_queue", exp_q.size(), 0);
    // tick_cnt saturation
    go(8'd1, 1'b1, n);
    for (int k = 1; k <= 257; k++) exp_q.push_back(n + 1 + k);
    repeat (258) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("sat_tick_cnt", tick_cnt, 255);
    chk("sat_queue", exp_q.size(), 0);
    step();
    // asynchronous reset mid-run
    go(8'd5, 1'b1, n);
    repeat (2) step();
    chk("rr_busy_before", busy, 1);
    #2;
    CLR_n = 1'b0;
    #1;
    chk("rr_busy", busy, 0);
    chk("rr_enp", cnt_enp, 0);
    chk("rr_ent", cnt_ent, 0);
    chk("rr_load_n", cnt_load_n, 1);
    chk("rr_cnt_d", cnt_d, 0);
    chk("rr_tick_cnt", tick_cnt, 0);
    step();
    chk("rr_done", done, 0);
    chk("rr_tick", tick, 0);
    CLR_n = 1'b1;
    step();
    chk("rr_done_after", done, 0);
    chk("end_queue", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end
endmodule
